// File: rtl/elbeth_pipe_ctrl.sv
// elbeth_pipe_ctrl: stage-register load/flush sequencing for the ELBETH core.
// Freezes the pipe across slow data-memory accesses and counts stall cycles.
module elbeth_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ack,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_sel_target,
  output logic        bus_err,
  output logic [31:0] stall_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_WAIT,
    S_ERROR
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          hazard;
  logic          active;
  logic          freeze;
  logic          rs1_hit;
  logic          rs2_hit;

  assign rs1_hit = (ex_rd_addr == id_rs1_addr);
  assign rs2_hit = id_uses_rs2 && (ex_rd_addr == id_rs2_addr);
  assign hazard  = ex_is_load && (ex_rd_addr != 5'd0)
                   && (rs1_hit || rs2_hit);

  assign active = (state == S_RUN) || (state == S_WAIT);

  // In WAIT the access is already outstanding, so only the ack matters.
  assign freeze = active && !dmem_ack
                  && (mem_access || (state == S_WAIT));

  always_comb begin
    dmem_req      = 1'b0;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    id_ex_we      = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_we     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_target = 1'b0;
    unique case (state)
      S_RESET: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      S_RUN, S_WAIT: begin
        dmem_req = mem_access || (state == S_WAIT);
        if (freeze) begin
          dmem_req = 1'b1;
        end else if (ex_branch_taken) begin
          pc_we         = 1'b1;
          pc_sel_target = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_we     = 1'b1;
          mem_wb_we     = 1'b1;
        end else if (hazard) begin
          id_ex_flush = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end else if (!if_ack) begin
          if_id_flush = 1'b1;
          id_ex_we    = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end
      end
      S_ERROR: begin
        dmem_req = 1'b0;
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (active && !pc_we && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      unique case (state)
        S_RESET: begin
          state     <= S_RUN;
          wait_cnt  <= '0;
          bus_err   <= 1'b0;
          stall_cnt <= '0;
        end
        S_RUN: begin
          if (freeze) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state <= S_RUN;
          end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            state   <= S_ERROR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_pipe_ctrl.sv
// tb_elbeth_pipe_ctrl: vector table plus memory-wait sequences,
// checked through an expected-result queue.
module tb_elbeth_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ack = 1'b0;
  logic [4:0]  id_rs1_addr = '0;
  logic [4:0]  id_rs2_addr = '0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        mem_access = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, pc_sel_target, bus_err;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  elbeth_pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .if_ack(if_ack),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr),
    .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access),
    .dmem_ack(dmem_ack),
    .dmem_req(dmem_req),
    .pc_we(pc_we),
    .if_id_we(if_id_we),
    .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .pc_sel_target(pc_sel_target),
    .bus_err(bus_err),
    .stall_cnt(stall_cnt)
  );

  // flag order: pc,ifid,idex,exmem,memwb,iff,idf,sel,req,err
  localparam logic [9:0] RST  = 10'b0000011000;
  localparam logic [9:0] ADV  = 10'b1111100000;
  localparam logic [9:0] ADVR = 10'b1111100010;
  localparam logic [9:0] LU   = 10'b0001101000;
  localparam logic [9:0] BR   = 10'b1001111100;
  localparam logic [9:0] BRR  = 10'b1001111110;
  localparam logic [9:0] FRZ  = 10'b0000000010;
  localparam logic [9:0] MISS = 10'b0011110000;
  localparam logic [9:0] ERR  = 10'b0000000001;
  localparam logic [9:0] C_ALL = 10'b1111111111;
  localparam logic [9:0] C_LU  = 10'b1101111111;
  localparam logic [9:0] C_BR  = 10'b1001111111;
  localparam logic [9:0] C_MS  = 10'b1011111111;

  typedef struct {
    int          id;
    logic        rst;
    logic        ifa;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        ld;
    logic        br;
    logic        ma;
    logic        ack;
    logic [9:0]  exp;
    logic [9:0]  care;
    logic [31:0] stall;
  } vec_t;

  vec_t tbl[30];
  vec_t sb[$];

  function automatic vec_t mk(
    input int id, input logic r, input logic ifa,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u2, input logic [4:0] rd,
    input logic ld, input logic br,
    input logic ma, input logic ack,
    input logic [9:0] exp, input logic [9:0] care,
    input logic [31:0] stall);
    vec_t v;
    v.id = id; v.rst = r; v.ifa = ifa;
    v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.ld = ld; v.br = br;
    v.ma = ma; v.ack = ack;
    v.exp = exp; v.care = care; v.stall = stall;
    return v;
  endfunction

  function automatic logic [9:0] flags();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we,
            mem_wb_we, if_id_flush, id_ex_flush,
            pc_sel_target, dmem_req, bus_err};
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    logic [9:0] f;
    @(posedge clk);
    #1;
    rst = v.rst;
    if_ack = v.ifa;
    id_rs1_addr = v.rs1;
    id_rs2_addr = v.rs2;
    id_uses_rs2 = v.u2;
    ex_rd_addr = v.rd;
    ex_is_load = v.ld;
    ex_branch_taken = v.br;
    mem_access = v.ma;
    dmem_ack = v.ack;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    f = flags();
    total++;
    if ((f & e.care) !== (e.exp & e.care)) begin
      bad++;
      $display("FAIL flags step%0d: got %b want %b care %b",
               e.id, f, e.exp, e.care);
    end
    total++;
    if (stall_cnt !== e.stall) begin
      bad++;
      $display("FAIL stall step%0d: got %0d want %0d",
               e.id, stall_cnt, e.stall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int k;
    tbl[0]  = mk(0, 1,0, 0,0,0,0, 0,0,0,0, RST, C_ALL, 0);
    tbl[1]  = mk(1, 0,1, 0,0,0,0, 0,0,0,0, RST, C_ALL, 0);
    tbl[2]  = mk(2, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 0);
    tbl[3]  = mk(3, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 0);
    tbl[4]  = mk(4, 0,1, 1,5,1,5, 1,0,0,0, LU,  C_LU,  0);
    tbl[5]  = mk(5, 0,1, 0,0,1,0, 1,0,0,0, ADV, C_ALL, 1);
    tbl[6]  = mk(6, 0,1, 7,2,0,7, 1,1,0,0, BR,  C_BR,  1);
    tbl[7]  = mk(7, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 1);
    tbl[8]  = mk(8, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 2);
    tbl[9]  = mk(9, 0,1, 0,0,0,0, 0,0,1,1, ADVR, C_ALL, 3);
    tbl[10] = mk(10, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 3);
    tbl[11] = mk(11, 0,0, 0,0,0,0, 0,0,0,0, MISS, C_MS, 3);
    tbl[12] = mk(12, 0,1, 0,0,0,0, 0,1,1,0, FRZ, C_ALL, 4);
    tbl[13] = mk(13, 0,1, 0,0,0,0, 0,1,1,1, BRR, C_BR, 5);
    tbl[14] = mk(14, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 5);
    tbl[15] = mk(15, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 5);
    tbl[16] = mk(16, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 6);
    tbl[17] = mk(17, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 7);
    tbl[18] = mk(18, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 8);
    tbl[19] = mk(19, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 9);
    tbl[20] = mk(20, 0,1, 0,0,0,0, 0,0,1,0, ERR, C_ALL, 10);
    tbl[21] = mk(21, 0,1, 0,0,0,0, 0,0,1,1, ERR, C_ALL, 10);
    tbl[22] = mk(22, 1,1, 0,0,0,0, 0,0,0,0, ERR, C_ALL, 10);
    tbl[23] = mk(23, 0,1, 0,0,0,0, 0,0,0,0, RST, C_ALL, 0);
    tbl[24] = mk(24, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 0);
    tbl[25] = mk(25, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 0);
    tbl[26] = mk(26, 1,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, 1);
    tbl[27] = mk(27, 0,1, 0,0,0,0, 0,0,0,1, RST, C_ALL, 0);
    tbl[28] = mk(28, 0,1, 0,0,0,0, 0,0,0,1, ADV, C_ALL, 0);
    tbl[29] = mk(29, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, 0);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i]);
    end

    // memory waits of 1..3 cycles: N frozen cycles, then advance
    base = 0;
    k = 100;
    for (int n = 1; n <= 3; n++) begin
      for (int j = 0; j < n; j++) begin
        step(mk(k, 0,1, 0,0,0,0, 0,0,1,0, FRZ, C_ALL, base + j));
        k++;
      end
      base += n;
      step(mk(k, 0,1, 0,0,0,0, 0,0,1,1, ADVR, C_ALL, base));
      k++;
    end
    step(mk(k, 0,1, 0,0,0,0, 0,0,0,0, ADV, C_ALL, base));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
